ex_stage: RTL and testbench

EX_STAGE -- requirements
Module: ex_stage

---
 rtl/ex_stage.sv | 200 ++++++++++++++++++++
 tb/tb_ex_stage.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/ex_stage.sv
// MIPS EX stage: operand select, ALU, branch target, EX/MEM register; mult via 32-cycle shift-add.
// Latency 1 edge (mult 33 edges); stall holds upstream during a multiply, flush inserts a bubble.
module ex_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        RegDst,
    input  logic        ALUSrc,
    input  logic        Branch,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic        MemtoReg,
    input  logic        RegWrite,
    input  logic [2:0]  AluOP,
    input  logic [31:0] add_pc,
    input  logic [31:0] data1,
    input  logic [31:0] data2,
    input  logic [31:0] sign_ex,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [5:0]  funct,
    output logic        stall,
    output logic        mem_RegWrite,
    output logic        mem_MemtoReg,
    output logic        mem_MemWrite,
    output logic        mem_MemRead,
    output logic        mem_Branch,
    output logic        mem_zero,
    output logic [31:0] mem_alu_result,
    output logic [31:0] mem_write_data,
    output logic [31:0] mem_branch_target,
    output logic [4:0]  mem_write_reg
);

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_RTYP = 3'b010;
    localparam logic [2:0] OP_AND  = 3'b011;
    localparam logic [2:0] OP_OR   = 3'b100;
    localparam logic [2:0] OP_SLT  = 3'b101;

    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_SLT  = 6'b101010;
    localparam logic [5:0] FN_MULT = 6'b011000;

    typedef enum logic {
        IDLE = 1'b0,
        MUL  = 1'b1
    } state_t;

    typedef struct packed {
        logic        reg_write;
        logic        mem_to_reg;
        logic        mem_write;
        logic        mem_read;
        logic        branch;
        logic        zero;
        logic [31:0] alu_result;
        logic [31:0] write_data;
        logic [31:0] branch_target;
        logic [4:0]  write_reg;
    } exmem_t;

    state_t      state_q, state_d;
    logic [31:0] mcand_q, mcand_d;
    logic [31:0] mplier_q, mplier_d;
    logic [31:0] acc_q, acc_d;
    logic [4:0]  cnt_q, cnt_d;
    exmem_t      exmem_q, exmem_d;

    logic [31:0] op_b;
    logic        is_mult;
    logic [31:0] alu_res;
    logic [31:0] acc_next;
    logic [31:0] res_sel;
    logic        load_full;
    logic        stall_c;
    exmem_t      full_rec;

    assign op_b    = ALUSrc ? sign_ex : data2;
    assign is_mult = (AluOP == OP_RTYP) && (funct == FN_MULT);

    always_comb begin
        alu_res = 32'd0;
        case (AluOP)
            OP_ADD: alu_res = data1 + op_b;
            OP_SUB: alu_res = data1 - op_b;
            OP_RTYP: begin
                case (funct)
                    FN_ADD:  alu_res = data1 + op_b;
                    FN_SUB:  alu_res = data1 - op_b;
                    FN_AND:  alu_res = data1 & op_b;
                    FN_OR:   alu_res = data1 | op_b;
                    FN_SLT:  alu_res = {31'd0, ($signed(data1) < $signed(op_b))};
                    default: alu_res = 32'd0;
                endcase
            end
            OP_AND:  alu_res = data1 & op_b;
            OP_OR:   alu_res = data1 | op_b;
            OP_SLT:  alu_res = {31'd0, ($signed(data1) < $signed(op_b))};
            default: alu_res = data1 + op_b;
        endcase
    end

    // One partial product per cycle, taken from the captured operands only.
    assign acc_next = acc_q + (mplier_q[cnt_q] ? (mcand_q << cnt_q) : 32'd0);

    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        stall_c   = 1'b0;
        load_full = 1'b0;
        res_sel   = alu_res;
        if (flush) begin
            state_d = IDLE;
            acc_d   = 32'd0;
            cnt_d   = 5'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (is_mult) begin
                        stall_c  = 1'b1;
                        mcand_d  = data1;
                        mplier_d = op_b;
                        acc_d    = 32'd0;
                        cnt_d    = 5'd0;
                        state_d  = MUL;
                    end else begin
                        load_full = 1'b1;
                    end
                end
                MUL: begin
                    acc_d = acc_next;
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == 5'd31) begin
                        load_full = 1'b1;
                        res_sel   = acc_next;
                        state_d   = IDLE;
                    end else begin
                        stall_c = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        full_rec.reg_write     = RegWrite;
        full_rec.mem_to_reg    = MemtoReg;
        full_rec.mem_write     = MemWrite;
        full_rec.mem_read      = MemRead;
        full_rec.branch        = Branch;
        full_rec.zero          = (res_sel == 32'd0);
        full_rec.alu_result    = res_sel;
        full_rec.write_data    = data2;
        full_rec.branch_target = add_pc + (sign_ex << 2);
        full_rec.write_reg     = RegDst ? rd : rt;
        exmem_d = load_full ? full_rec : '0;
    end

    // Reset gating keeps stall low even if a mult decode sits on the inputs during reset.
    assign stall = rst_n & stall_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            mcand_q  <= 32'd0;
            mplier_q <= 32'd0;
            acc_q    <= 32'd0;
            cnt_q    <= 5'd0;
            exmem_q  <= '0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            exmem_q  <= exmem_d;
        end
    end

    assign mem_RegWrite      = exmem_q.reg_write;
    assign mem_MemtoReg      = exmem_q.mem_to_reg;
    assign mem_MemWrite      = exmem_q.mem_write;
    assign mem_MemRead       = exmem_q.mem_read;
    assign mem_Branch        = exmem_q.branch;
    assign mem_zero          = exmem_q.zero;
    assign mem_alu_result    = exmem_q.alu_result;
    assign mem_write_data    = exmem_q.write_data;
    assign mem_branch_target = exmem_q.branch_target;
    assign mem_write_reg     = exmem_q.write_reg;

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: per-cycle expected EX/MEM records queued at drive time, popped after the edge.
module tb_ex_stage;

    typedef struct packed {
        logic [5:0]  ctrl;   // RegWrite, MemtoReg, MemWrite, MemRead, Branch, zero
        logic [31:0] alu;
        logic [31:0] wdata;
        logic [31:0] btgt;
        logic [4:0]  wreg;
    } rec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        RegDst, ALUSrc, Branch, MemRead, MemWrite, MemtoReg, RegWrite;
    logic [2:0]  AluOP;
    logic [31:0] add_pc, data1, data2, sign_ex;
    logic [4:0]  rt, rd;
    logic [5:0]  funct;
    logic        stall;
    logic        mem_RegWrite, mem_MemtoReg, mem_MemWrite, mem_MemRead, mem_Branch, mem_zero;
    logic [31:0] mem_alu_result, mem_write_data, mem_branch_target;
    logic [4:0]  mem_write_reg;

    int   n_tests = 0;
    int   n_fail  = 0;
    rec_t sb_q[$];
    rec_t bubble = '0;

    ex_stage dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .RegDst(RegDst), .ALUSrc(ALUSrc), .Branch(Branch), .MemRead(MemRead),
        .MemWrite(MemWrite), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
        .AluOP(AluOP), .add_pc(add_pc), .data1(data1), .data2(data2), .sign_ex(sign_ex),
        .rt(rt), .rd(rd), .funct(funct), .stall(stall),
        .mem_RegWrite(mem_RegWrite), .mem_MemtoReg(mem_MemtoReg), .mem_MemWrite(mem_MemWrite),
        .mem_MemRead(mem_MemRead), .mem_Branch(mem_Branch), .mem_zero(mem_zero),
        .mem_alu_result(mem_alu_result), .mem_write_data(mem_write_data),
        .mem_branch_target(mem_branch_target), .mem_write_reg(mem_write_reg)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                            input logic [2:0] op, input logic [5:0] f);
        case (op)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: begin
                case (f)
                    6'h20:   return a + b;
                    6'h22:   return a - b;
                    6'h24:   return a & b;
                    6'h25:   return a | b;
                    6'h2A:   return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                    6'h18:   return a * b;
                    default: return 32'd0;
                endcase
            end
            3'd3: return a & b;
            3'd4: return a | b;
            3'd5: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: return a + b;
        endcase
    endfunction

    function automatic rec_t model_rec(input logic [31:0] a);
        rec_t        r;
        logic [31:0] b;
        b       = ALUSrc ? sign_ex : data2;
        r.alu   = alu_ref(a, b, AluOP, funct);
        r.ctrl  = {RegWrite, MemtoReg, MemWrite, MemRead, Branch, (r.alu == 32'd0)};
        r.wdata = data2;
        r.btgt  = add_pc + {sign_ex[29:0], 2'b00};
        r.wreg  = RegDst ? rd : rt;
        return r;
    endfunction

    function automatic rec_t dut_rec();
        rec_t r;
        r.ctrl  = {mem_RegWrite, mem_MemtoReg, mem_MemWrite, mem_MemRead, mem_Branch, mem_zero};
        r.alu   = mem_alu_result;
        r.wdata = mem_write_data;
        r.btgt  = mem_branch_target;
        r.wreg  = mem_write_reg;
        return r;
    endfunction

    task automatic cmp_rec(input string tag, input rec_t got, input rec_t exp);
        check({tag, "/ctrl"},  {26'd0, got.ctrl}, {26'd0, exp.ctrl});
        check({tag, "/alu"},   got.alu,   exp.alu);
        check({tag, "/wdata"}, got.wdata, exp.wdata);
        check({tag, "/btgt"},  got.btgt,  exp.btgt);
        check({tag, "/wreg"},  {27'd0, got.wreg}, {27'd0, exp.wreg});
    endtask

    // Called just after a negedge with inputs driven; returns at the following negedge.
    task automatic step(input string tag, input logic exp_stall, input rec_t er);
        rec_t exp;
        #1;
        check({tag, "/stall"}, {31'd0, stall}, {31'd0, exp_stall});
        sb_q.push_back(er);
        @(posedge clk);
        #1;
        exp = sb_q.pop_front();
        cmp_rec(tag, dut_rec(), exp);
        @(negedge clk);
    endtask

    task automatic drive(input logic rdst, input logic asrc, input logic br, input logic mr,
                         input logic mw, input logic m2r, input logic rw, input logic [2:0] op,
                         input logic [31:0] pc, input logic [31:0] d1, input logic [31:0] d2,
                         input logic [31:0] sx, input logic [4:0] t, input logic [4:0] d,
                         input logic [5:0] f);
        RegDst = rdst; ALUSrc = asrc; Branch = br; MemRead = mr; MemWrite = mw;
        MemtoReg = m2r; RegWrite = rw; AluOP = op; add_pc = pc; data1 = d1; data2 = d2;
        sign_ex = sx; rt = t; rd = d; funct = f;
    endtask

    task automatic op(input string tag, input logic rdst, input logic asrc, input logic br,
                      input logic [2:0] aop, input logic [31:0] d1, input logic [31:0] d2,
                      input logic [31:0] sx, input logic [5:0] f);
        drive(rdst, asrc, br, 1'b0, 1'b0, 1'b0, 1'b1, aop, 32'h0000_0040, d1, d2, sx,
              5'd9, 5'd3, f);
        step(tag, 1'b0, model_rec(data1));
    endtask

    // Full multiply; data1 is disturbed mid-sequence to show captured operands are used.
    task automatic run_mult(input string tag, input logic [31:0] a, input logic [31:0] b);
        rec_t exp;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'b010, 32'h0000_0200, a, b,
              32'h0000_0010, 5'd4, 5'd8, 6'b011000);
        exp = model_rec(a);
        for (int i = 0; i < 32; i++) begin
            if (i == 5) data1 = ~a;
            step($sformatf("%s/bub%0d", tag, i), 1'b1, bubble);
        end
        step({tag, "/res"}, 1'b0, exp);
        data1 = a;
    endtask

    task automatic check_zero_outputs(input string tag);
        cmp_rec(tag, dut_rec(), bubble);
        check({tag, "/stall"}, {31'd0, stall}, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        flush = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b010, 32'd0, 32'd1, 32'd1, 32'd0,
              5'd0, 5'd0, 6'b011000);
        repeat (2) @(negedge clk);
        check_zero_outputs("reset");
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0, 32'd0, 32'd0,
              5'd0, 5'd0, 6'd0);
        rst_n = 1'b1;

        // R-type add
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'b010, 32'h0000_0004, 32'd7, 32'd5,
              32'd0, 5'd0, 5'd3, 6'b100000);
        step("radd", 1'b0, model_rec(data1));
        // beq-class compare
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b001, 32'h0000_0100, 32'h1234,
              32'h1234, 32'hFFFF_FFFE, 5'd1, 5'd2, 6'd0);
        step("beq", 1'b0, model_rec(data1));
        // slti
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'b101, 32'h0000_0008, 32'hFFFF_FFFF,
              32'd77, 32'd1, 5'd9, 5'd12, 6'd0);
        step("slti", 1'b0, model_rec(data1));
        // sw-style: MemWrite with immediate add
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'b000, 32'h0000_0010, 32'h1000,
              32'hCAFE_F00D, 32'h0000_0020, 5'd6, 5'd7, 6'd0);
        step("sw", 1'b0, model_rec(data1));
        op("rsub",   1'b1, 1'b0, 1'b0, 3'b010, 32'd5, 32'd7, 32'd0, 6'b100010);
        op("rand",   1'b1, 1'b0, 1'b0, 3'b010, 32'hF0F0_1234, 32'h0FF0_FF00, 32'd0, 6'b100100);
        op("ror",    1'b1, 1'b0, 1'b0, 3'b010, 32'hF000_0001, 32'h0000_0F10, 32'd0, 6'b100101);
        op("rslt",   1'b1, 1'b0, 1'b0, 3'b010, 32'h8000_0000, 32'd1, 32'd0, 6'b101010);
        op("rsltn",  1'b1, 1'b0, 1'b0, 3'b010, 32'd1, 32'h8000_0000, 32'd0, 6'b101010);
        op("rbadfn", 1'b1, 1'b0, 1'b0, 3'b010, 32'd9, 32'd9, 32'd0, 6'b111111);
        op("andi",   1'b0, 1'b1, 1'b0, 3'b011, 32'hABCD_EF01, 32'd0, 32'h0000_FF0F, 6'd0);
        op("ori",    1'b0, 1'b1, 1'b0, 3'b100, 32'h1200_0000, 32'd0, 32'h0000_0034, 6'd0);
        op("addwrap",1'b0, 1'b1, 1'b0, 3'b110, 32'hFFFF_FFFF, 32'd0, 32'd1, 6'd0);
        op("op111",  1'b0, 1'b0, 1'b1, 3'b111, 32'd100, 32'd23, 32'hFFFF_FFF0, 6'd0);

        // Multiply, then a second one right after completion
        run_mult("mult1", 32'h0001_0003, 32'h0002_0005);
        run_mult("mult2", 32'hFFFF_FFFD, 32'h0000_0007);

        // Flush at count=10, then the held mult restarts from scratch
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'b010, 32'h0000_0300, 32'h0000_1234,
              32'h0000_0011, 32'd0, 5'd1, 5'd2, 6'b011000);
        for (int i = 0; i < 11; i++) step($sformatf("fl/bub%0d", i), 1'b1, bubble);
        flush = 1'b1;
        step("fl/flush", 1'b0, bubble);
        flush = 1'b0;
        run_mult("flmult", 32'h0000_1234, 32'h0000_0011);
        // Flush with a mult decode waiting in IDLE, and with a normal op
        flush = 1'b1;
        step("fl/idlemult", 1'b0, bubble);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'b010, 32'd4, 32'd1, 32'd2, 32'd0,
              5'd1, 5'd2, 6'b100000);
        step("fl/add", 1'b0, bubble);
        flush = 1'b0;
        step("afterfl", 1'b0, model_rec(data1));

        // Async reset between edges clears a non-zero record immediately
        #2 rst_n = 1'b0;
        #1 check_zero_outputs("arst");
        @(negedge clk);
        rst_n = 1'b1;

        // Reset mid-multiply: stall drops, no result emerges afterwards
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'b010, 32'h0000_0400, 32'd6, 32'd7,
              32'd0, 5'd1, 5'd2, 6'b011000);
        for (int i = 0; i < 6; i++) step($sformatf("rm/bub%0d", i), 1'b1, bubble);
        #2 rst_n = 1'b0;
        #1 check_zero_outputs("rm/low");
        @(posedge clk);
        #1 check_zero_outputs("rm/lowedge");
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'b010, 32'h0000_0400, 32'd6, 32'd7,
              32'd0, 5'd1, 5'd2, 6'b100000);
        rst_n = 1'b1;
        for (int i = 0; i < 30; i++) step($sformatf("rm/post%0d", i), 1'b0, model_rec(data1));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
